otf_converter: RTL and testbench

OTF_CONVERTER -- requirements
Module: otf_converter

---
 rtl/otf_converter_pkg.sv | 23 ++
 rtl/otf_append.sv | 54 +++++
 rtl/otf_converter.sv | 115 +++++++++++
 tb/tb_otf_converter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/otf_converter_pkg.sv
// Shared encodings for the on-the-fly converter and the online multiplier
// digit-selection logic: signed-digit codes, FSM states, digit helpers.
package otf_converter_pkg;

  // Signed radix-2 digit encoding {neg,pos}
  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b01;
  localparam logic [1:0] DIG_NEG  = 2'b10;
  localparam logic [1:0] DIG_ILL  = 2'b11;

  // Converter control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CONV = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // True when both digit rails are set, which has no numeric meaning
  function automatic logic dig_is_illegal(input logic [1:0] d);
    return (d == DIG_ILL);
  endfunction

endpackage

// File: rtl/otf_append.sv
// Combinational on-the-fly append step: given the running value Q and its
// companion QM = Q-1, produce both next values for one more signed digit.
// Only shifts and a fixed LSB are used; no carry chain is involved.
module otf_append
  import otf_converter_pkg::*;
#(
  parameter int Stage = 6
) (
  input  logic [Stage:0] q,
  input  logic [Stage:0] qm,
  input  logic [1:0]     digit,
  output logic [Stage:0] q_next,
  output logic [Stage:0] qm_next,
  output logic           illegal
);

  localparam logic [Stage:0] LSB_ONE = {{Stage{1'b0}}, 1'b1};

  logic [Stage:0] q_sh_s;
  logic [Stage:0] qm_sh_s;

  assign q_sh_s  = q  << 1'b1;
  assign qm_sh_s = qm << 1'b1;

  // Select the appended pair; illegal digits behave as zero
  always_comb begin
    q_next  = q_sh_s;
    qm_next = qm_sh_s | LSB_ONE;
    illegal = dig_is_illegal(digit);
    case (digit)
      DIG_POS: begin
        q_next  = q_sh_s | LSB_ONE;
        qm_next = q_sh_s;
      end
      DIG_NEG: begin
        q_next  = qm_sh_s | LSB_ONE;
        qm_next = qm_sh_s;
      end
      DIG_ZERO: begin
        q_next  = q_sh_s;
        qm_next = qm_sh_s | LSB_ONE;
      end
      DIG_ILL: begin
        q_next  = q_sh_s;
        qm_next = qm_sh_s | LSB_ONE;
      end
      default: begin
        q_next  = q_sh_s;
        qm_next = qm_sh_s | LSB_ONE;
      end
    endcase
  end

endmodule

// File: rtl/otf_converter.sv
// On-the-fly converter: turns an MSD-first stream of Stage signed radix-2
// digits into a two's-complement value of Stage+1 bits with no carry
// propagation. Control is a three-state FSM with a digit counter.
module otf_converter
  import otf_converter_pkg::*;
#(
  parameter int Stage = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           digit_valid,
  input  logic [1:0]     digit,
  output logic           digit_ready,
  output logic [Stage:0] result,
  output logic           done,
  output logic           err
);

  localparam int CntW = $clog2(Stage + 1);
  localparam logic [CntW-1:0]  CNT_ONE  = CntW'(1);
  localparam logic [CntW-1:0]  LAST_CNT = CntW'(Stage - 1);
  localparam logic [Stage:0]   ALL_ONES = {(Stage + 1){1'b1}};
  localparam logic [Stage:0]   ALL_ZERO = {(Stage + 1){1'b0}};

  state_t          state_r;
  state_t          state_next_s;
  logic [CntW-1:0] cnt_r;
  logic [Stage:0]  q_r;
  logic [Stage:0]  qm_r;
  logic            err_r;

  logic            accept_s;
  logic            last_s;
  logic [Stage:0]  q_next_s;
  logic [Stage:0]  qm_next_s;
  logic            illegal_s;

  // A digit counts only in CONV and never in a start cycle
  assign accept_s = (state_r == ST_CONV) && digit_valid && !start;
  assign last_s   = (cnt_r == LAST_CNT);

  otf_append #(
    .Stage (Stage)
  ) u_append (
    .q       (q_r),
    .qm      (qm_r),
    .digit   (digit),
    .q_next  (q_next_s),
    .qm_next (qm_next_s),
    .illegal (illegal_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; start wins from every state
  always_comb begin
    state_next_s = state_r;
    if (start) begin
      state_next_s = ST_CONV;
    end else begin
      case (state_r)
        ST_IDLE: state_next_s = ST_IDLE;
        ST_CONV: begin
          if (accept_s && last_s) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_CONV;
          end
        end
        ST_DONE: state_next_s = ST_DONE;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // Running value pair, digit counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r   <= ALL_ZERO;
      qm_r  <= ALL_ONES;
      cnt_r <= {CntW{1'b0}};
      err_r <= 1'b0;
    end else if (start) begin
      q_r   <= ALL_ZERO;
      qm_r  <= ALL_ONES;
      cnt_r <= {CntW{1'b0}};
      err_r <= 1'b0;
    end else if (accept_s) begin
      q_r   <= q_next_s;
      qm_r  <= qm_next_s;
      cnt_r <= cnt_r + CNT_ONE;
      err_r <= err_r | illegal_s;
    end else begin
      q_r   <= q_r;
      qm_r  <= qm_r;
      cnt_r <= cnt_r;
      err_r <= err_r;
    end
  end

  // Outputs come straight from registers so no input reaches them combinationally
  assign result      = q_r;
  assign err         = err_r;
  assign done        = (state_r == ST_DONE);
  assign digit_ready = (state_r == ST_CONV);

endmodule

// File: tb/tb_otf_converter.sv
// Self-checking bench for otf_converter (Stage=6): directed digit strings
// plus randomized conversions, checked against an integer-valued model.
module tb_otf_converter;

  localparam int Stage = 6;

  logic           clk;
  logic           rst;
  logic           start;
  logic           digit_valid;
  logic [1:0]     digit;
  logic           digit_ready;
  logic [Stage:0] result;
  logic           done;
  logic           err;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0=idle 1=conv 2=done, value kept as an integer
  int m_phase = 0;
  int m_val   = 0;
  int m_cnt   = 0;
  int m_err   = 0;

  otf_converter #(.Stage(Stage)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .digit_valid (digit_valid),
    .digit       (digit),
    .digit_ready (digit_ready),
    .result      (result),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input int d);
    if (d == 1) return 2'b01;
    else if (d == -1) return 2'b10;
    else if (d == 2) return 2'b11;
    else return 2'b00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_val = 0; m_cnt = 0; m_err = 0;
  endtask

  // Apply the currently driven inputs to the model, as one clock edge would
  task automatic model_edge();
    int dv;
    if (start) begin
      m_phase = 1; m_val = 0; m_cnt = 0; m_err = 0;
    end else if (m_phase == 1 && digit_valid) begin
      if (digit == 2'b01) dv = 1;
      else if (digit == 2'b10) dv = -1;
      else dv = 0;
      if (digit == 2'b11) m_err = 1;
      m_val = 2 * m_val + dv;
      m_cnt++;
      if (m_cnt == Stage) m_phase = 2;
    end
  endtask

  task automatic check_all(input string tag);
    logic [Stage:0] ev;
    ev = m_val[Stage:0];
    check({tag, ".result"}, 32'(result), 32'(ev));
    check({tag, ".done"}, 32'(done), 32'(m_phase == 2));
    check({tag, ".ready"}, 32'(digit_ready), 32'(m_phase == 1));
    check({tag, ".err"}, 32'(err), 32'(m_err));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_start();
    start = 1'b1; digit_valid = 1'b0; digit = 2'b00;
    tick("start");
    start = 1'b0;
  endtask

  // Feed six digits, with gap idle cycles between them, then check the value
  task automatic run_digits(input int d0, d1, d2, d3, d4, d5, input int gap,
                            input int exp_val, input int exp_err, input string tag);
    int ds[6];
    logic [Stage:0] ev;
    ds = '{d0, d1, d2, d3, d4, d5};
    do_start();
    for (int i = 0; i < 6; i++) begin
      for (int g = 0; g < gap; g++) begin
        digit_valid = 1'b0; digit = enc(1);
        tick({tag, ".gap"});
      end
      digit_valid = 1'b1; digit = enc(ds[i]);
      tick(tag);
    end
    digit_valid = 1'b0;
    ev = exp_val[Stage:0];
    check({tag, ".final"}, 32'(result), 32'(ev));
    check({tag, ".final_err"}, 32'(err), 32'(exp_err));
    check({tag, ".final_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; start = 1'b0; digit_valid = 1'b0; digit = 2'b00;
    #1 rst = 1'b1;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Digits while idle are ignored
    digit_valid = 1'b1; digit = enc(1);
    tick("idle_ignore");
    tick("idle_ignore");

    run_digits(1, 0, -1, 0, 0, 1, 0, 25, 0, "basic25");
    // DONE holds its value even with more digits offered
    digit_valid = 1'b1; digit = enc(-1);
    tick("done_hold");
    tick("done_hold");
    digit_valid = 1'b0;

    run_digits(-1, -1, -1, -1, -1, -1, 0, -63, 0, "neg63");
    run_digits(1, 1, 1, 1, 1, 1, 0, 63, 0, "pos63");
    run_digits(1, 0, -1, 0, 0, 1, 2, 25, 0, "gaps25");
    run_digits(-1, 2, 1, 0, 0, 0, 0, -24, 1, "illegal");
    tick("illegal_hold");
    check("illegal_sticky", 32'(err), 32'd1);

    // Restart mid-conversion; the digit in the start cycle is dropped
    do_start();
    for (int i = 0; i < 3; i++) begin
      digit_valid = 1'b1; digit = enc(-1);
      tick("restart_pre");
    end
    run_digits(0, 0, 0, 0, 0, 1, 0, 1, 0, "restart1");
    start = 1'b1; digit_valid = 1'b1; digit = enc(1);
    tick("start_digit");
    check("start_digit_val", 32'(result), 32'd0);
    start = 1'b0; digit_valid = 1'b0;

    // Async reset pulse between edges mid-conversion
    digit_valid = 1'b1; digit = enc(1);
    tick("prerst");
    tick("prerst");
    #3 rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    #1 rst = 1'b0;
    digit_valid = 1'b1; digit = enc(1);
    tick("post_rst");
    tick("post_rst");
    digit_valid = 1'b0;

    // Randomized conversions with gaps, illegal digits and occasional restarts
    for (int n = 0; n < 25; n++) begin
      int budget;
      do_start();
      budget = 0;
      while (m_phase != 2 && budget < 200) begin
        int r;
        r = int'($urandom_range(0, 39));
        start = (r == 0);
        digit_valid = ($urandom_range(0, 3) != 0);
        r = int'($urandom_range(0, 9));
        digit = (r == 0) ? 2'b11 : enc(int'($urandom_range(0, 2)) - 1);
        tick("rand");
        start = 1'b0;
        budget++;
      end
      check("rand_budget", 32'(budget < 200), 32'd1);
      digit_valid = 1'b0;
      tick("rand_done");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
